// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between the execute path and a buffered long-latency path
module rf_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        hazard_rs1,
  output logic        hazard_rs2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ll_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0] mem_rd [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic [SW-1:0] starve_cnt;
  logic [DEPTH-1:0] live;
  logic empty, full, force_drain, sel_ex, deq, enq;
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign force_drain = !empty && starve_cnt == SW'(STARVE_MAX);
  assign ex_ready = !force_drain;
  assign ll_ready = !full;
  assign ll_pending = !empty;
  assign sel_ex = !force_drain && ex_valid && ex_rd != '0;
  assign deq = force_drain || (!ex_valid && !empty);
  assign enq = ll_valid && !full && ll_rd != '0;
  for (genvar g = 0; g < DEPTH; g++) begin : g_live
    assign live[g] = {1'b0, AW'(AW'(g) - rd_ptr[AW-1:0])} < count;
  end
  always_comb begin
    hazard_rs1 = rf_we && rf_waddr == chk_rs1;
    hazard_rs2 = rf_we && rf_waddr == chk_rs2;
    for (int i = 0; i < DEPTH; i++) begin
      hazard_rs1 = hazard_rs1 || (live[i] && mem_rd[i] == chk_rs1);
      hazard_rs2 = hazard_rs2 || (live[i] && mem_rd[i] == chk_rs2);
    end
    hazard_rs1 = hazard_rs1 && chk_rs1 != '0;
    hazard_rs2 = hazard_rs2 && chk_rs2 != '0;
  end
  always_ff @(posedge clk)
    if (enq) begin
      mem_rd[wr_ptr[AW-1:0]] <= ll_rd;
      mem_data[wr_ptr[AW-1:0]] <= ll_data;
    end
  always_ff @(posedge clk)
    if (rst) begin
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      starve_cnt <= '0;
    end else begin
      rf_we <= sel_ex || deq;
      if (sel_ex || deq) begin
        rf_waddr <= sel_ex ? ex_rd : mem_rd[rd_ptr[AW-1:0]];
        rf_wdata <= sel_ex ? ex_data : mem_data[rd_ptr[AW-1:0]];
      end
      if (enq) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (deq) rd_ptr <= rd_ptr + (AW+1)'(1);
      starve_cnt <= (deq || empty) ? '0 : starve_cnt + SW'(starve_cnt != SW'(STARVE_MAX));
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized scoreboard bench against a queue-based reference model
module tb_rf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} ent_t;
  typedef struct packed {int cyc; logic [4:0] rd; logic [31:0] data;} exp_t;
  logic clk = 0, rst = 1;
  logic ex_valid = 0, ex_ready, ll_valid = 0, ll_ready;
  logic [4:0] ex_rd = 0, ll_rd = 0, chk_rs1 = 0, chk_rs2 = 0, rf_waddr;
  logic [31:0] ex_data = 0, ll_data = 0, rf_wdata;
  logic hazard_rs1, hazard_rs2, rf_we, ll_pending;
  ent_t q[$];
  exp_t sb[$];
  exp_t e;
  int starve = 0, checks = 0, errors = 0, cyc_cnt = 0;
  bit lw = 0, ex_ok = 1, ll_ok = 1;
  logic [4:0] la = 0;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ll_pending(ll_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] rnd_rd();
    int k = $urandom_range(9);
    return k < 2 ? 5'd0 : k < 9 ? 5'($urandom_range(1, 7)) : 5'($urandom);
  endfunction

  always @(negedge clk) begin
    if (rf_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: got rf_we=1 rd=%0d data=%0h expected rf_we=0", rf_waddr, rf_wdata);
      end else begin
        e = sb.pop_front();
        chk("write_cycle", cyc_cnt, e.cyc);
        chk("rf_waddr", rf_waddr, e.rd);
        chk("rf_wdata", rf_wdata, e.data);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: got rf_we=0 expected rf_we=1 rd=%0d data=%0h", e.rd, e.data);
    end
  end

  task automatic run_cycle(input bit r, input int p_ex, input int p_ll);
    bit force_d, h1, h2, has, deq, lacc;
    int pre;
    ent_t w;
    @(posedge clk);
    #1;
    rst = r;
    if (!(ex_valid && !ex_ok)) begin
      ex_valid = $urandom_range(99) < p_ex;
      ex_rd = rnd_rd();
      ex_data = $urandom;
    end
    if (!(ll_valid && !ll_ok)) begin
      ll_valid = $urandom_range(99) < p_ll;
      ll_rd = rnd_rd();
      ll_data = $urandom;
    end
    chk_rs1 = rnd_rd();
    chk_rs2 = rnd_rd();
    #1;
    if (r) begin
      q.delete();
      starve = 0;
      lw = 0;
      ex_ok = 1;
      ll_ok = 1;
      return;
    end
    force_d = q.size() > 0 && starve == SMAX;
    h1 = lw && la == chk_rs1;
    h2 = lw && la == chk_rs2;
    foreach (q[i]) begin
      h1 |= q[i].rd == chk_rs1;
      h2 |= q[i].rd == chk_rs2;
    end
    h1 &= chk_rs1 != 0;
    h2 &= chk_rs2 != 0;
    chk("ex_ready", ex_ready, !force_d);
    chk("ll_ready", ll_ready, q.size() < DEPTH);
    chk("ll_pending", ll_pending, q.size() != 0);
    chk("hazard_rs1", hazard_rs1, h1);
    chk("hazard_rs2", hazard_rs2, h2);
    pre = q.size();
    lacc = ll_valid && pre < DEPTH;
    has = 0;
    deq = 0;
    if (force_d || (!ex_valid && pre > 0)) begin
      w = q.pop_front();
      has = 1;
      deq = 1;
    end else if (ex_valid && ex_rd != 0) begin
      w = '{ex_rd, ex_data};
      has = 1;
    end
    if (lacc && ll_rd != 0) q.push_back('{ll_rd, ll_data});
    starve = (deq || pre == 0) ? 0 : (starve < SMAX ? starve + 1 : SMAX);
    if (has) begin
      sb.push_back('{cyc_cnt + 1, w.rd, w.data});
      la = w.rd;
    end
    lw = has;
    ex_ok = !force_d;
    ll_ok = pre < DEPTH;
  endtask

  initial begin
    ex_valid = 1;
    ex_rd = 5;
    ex_data = 32'h11;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    ex_valid = 0;
    #1;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_waddr", rf_waddr, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_ll_ready", ll_ready, 1);
    chk("reset_ll_pending", ll_pending, 0);
    chk("reset_ex_ready", ex_ready, 1);
    repeat (200) run_cycle(0, 100, 40);
    repeat (100) run_cycle(0, 0, 50);
    repeat (300) run_cycle($urandom_range(149) == 0, 60, 60);
    repeat (200) run_cycle(0, 100, 90);
    repeat (200) run_cycle($urandom_range(99) == 0, 30, 20);
    repeat (300) run_cycle(0, 85, 70);
    repeat (40) run_cycle(0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("model_fifo_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
